// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between four writeback sources:
//     0 = pipeline WB, 1 = load return, 2 = mul/div completion, 3 = CP0/mfc0.
//   Each cycle the pending requests are arbitrated combinationally, the winner
//   is acknowledged in the same cycle, and its address/data are registered so
//   the register file sees the write exactly one cycle after the grant.
//
//   Source 0 normally has fixed priority. Sources 1..3 share a round-robin
//   pointer. Any source in 1..3 that has been waiting STARVE_LIMIT cycles
//   preempts source 0, so the pipeline cannot lock out the slow units.
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous, active-high reset
//   stall_i   in   1    1: grant nothing this cycle
//   req_i     in   4    per-source write request, bit k = source k
//   addrK_i   in   AW   destination register of source K (K = 0..3)
//   dataK_i   in   DW   write data of source K (K = 0..3)
//   ack_o     out  4    one-hot, combinational: request accepted this cycle
//   sel_o     out  2    registered index of the last winner (write-mux select)
//   we_o      out  1    registered register-file write enable
//   waddr_o   out  AW   registered write address
//   wdata_o   out  DW   registered write data
//   starve_o  out  1    registered: last grant was a starvation preemption
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rf_wb_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4,   // legal range 1..15
  parameter int DROP_R0      = 1    // 1: writes to r0 are acked but suppressed
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic [3:0]    req_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [AW-1:0] addr2_i,
  input  logic [AW-1:0] addr3_i,
  input  logic [DW-1:0] data0_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic [DW-1:0] data3_i,
  output logic [3:0]    ack_o,
  output logic [1:0]    sel_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o,
  output logic          starve_o
);

  // Wait counters only need to reach STARVE_LIMIT, which is at most 15.
  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // Per-source views of the request payloads
  // ---------------------------------------------------------------------------
  logic [3:0][AW-1:0] addr_arr;
  logic [3:0][DW-1:0] data_arr;

  assign addr_arr[0] = addr0_i;
  assign addr_arr[1] = addr1_i;
  assign addr_arr[2] = addr2_i;
  assign addr_arr[3] = addr3_i;
  assign data_arr[0] = data0_i;
  assign data_arr[1] = data1_i;
  assign data_arr[2] = data2_i;
  assign data_arr[3] = data3_i;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          rr_ptr_q, rr_ptr_d;     // next source in 1..3 to favour
  logic [3:1][CW-1:0]  wait_q,   wait_d;       // cycles each source has waited
  logic [1:0]          sel_q,    sel_d;
  logic                we_q,     we_d;
  logic [AW-1:0]       waddr_q,  waddr_d;
  logic [DW-1:0]       wdata_q,  wdata_d;
  logic                starve_q, starve_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [3:0] starve_mask;   // sources 1..3 that have hit the wait limit
  logic [3:0] grant_oh;      // one-hot winner, before reset gating
  logic       grant;
  logic       grant_starve;  // grant came from the starvation rule
  logic [1:0] win_idx;

  // Round-robin search over sources 1..3 starting at ptr. Returns 0 when the
  // mask is empty; callers only use the result when the mask is non-empty.
  // Bit 0 of the mask is ignored (source 0 never takes part in round-robin).
  function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    idx   = ptr;
    res   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
    end
    return res;
  endfunction

  assign starve_mask[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_starve
      assign starve_mask[gi] = req_i[gi] && (wait_q[gi] == LIMIT);
    end
  endgenerate

  always_comb begin
    grant        = 1'b0;
    grant_starve = 1'b0;
    win_idx      = 2'd0;
    if (!stall_i) begin
      if (|starve_mask) begin
        grant        = 1'b1;
        grant_starve = 1'b1;
        win_idx      = rr_pick(starve_mask, rr_ptr_q);
      end else if (req_i[0]) begin
        grant   = 1'b1;
        win_idx = 2'd0;
      end else if (|req_i[3:1]) begin
        grant   = 1'b1;
        win_idx = rr_pick({req_i[3:1], 1'b0}, rr_ptr_q);
      end
    end
  end

  assign grant_oh = grant ? (4'b0001 << win_idx) : 4'b0000;

  // Reset is asynchronous, so the handshake must also go quiet immediately
  // rather than waiting for the registers to settle.
  assign ack_o = rst ? 4'b0000 : grant_oh;

  // ---------------------------------------------------------------------------
  // Wait counters: any cycle a source is requesting but not acked counts,
  // including stalled cycles, so a long stall can itself trigger preemption.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_wait
      always_comb begin
        wait_d[gi] = wait_q[gi];
        if (!req_i[gi] || grant_oh[gi]) begin
          wait_d[gi] = '0;
        end else if (wait_q[gi] != LIMIT) begin
          wait_d[gi] = wait_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state for pointer and write-port registers
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    starve_d = 1'b0;

    if (grant) begin
      sel_d    = win_idx;
      waddr_d  = addr_arr[win_idx];
      wdata_d  = data_arr[win_idx];
      starve_d = grant_starve;
      // r0 is hard-wired zero: the source still gets its ack so it can
      // retire, but the register file never sees the write.
      we_d     = !((DROP_R0 != 0) && (addr_arr[win_idx] == '0));

      // Only round-robin participants advance the pointer.
      if (win_idx != 2'd0) begin
        rr_ptr_d = (win_idx == 2'd3) ? 2'd1 : win_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 2'd1;
      wait_q   <= '0;
      sel_q    <= 2'd0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      starve_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  assign sel_o    = sel_q;
  assign we_o     = we_q;
  assign waddr_o  = waddr_q;
  assign wdata_o  = wdata_q;
  assign starve_o = starve_q;

endmodule
